// File: rtl/meas_result_pkg.sv
// Shared constants for the measurement result FIFO: entry layout, field offsets, saturation limit.
// Entry layout grows by a 32-bit timestamp when MEAS_TIMESTAMP_EN is defined.
package meas_result_pkg;

    localparam int ACCW_DEF = 32;
    localparam int TS_W     = 32;

`ifdef MEAS_TIMESTAMP_EN
    localparam int TS_STORE_W = TS_W;
`else
    localparam int TS_STORE_W = 0;
`endif

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    localparam int OFF_RX   = 0;
    localparam int OFF_RY   = 1;
    localparam int OFF_XACC = 2;

    function automatic int off_yacc(input int accw);
        return 2 + accw;
    endfunction

    function automatic int off_ts(input int accw);
        return 2 + 2 * accw;
    endfunction

    function automatic int entry_w(input int accw);
        return 2 + 2 * accw + TS_STORE_W;
    endfunction

endpackage

// File: rtl/meas_result_mem.sv
// Result FIFO storage: DEPTH x W register array, one synchronous write port, one asynchronous read port.
// Storage carries no reset; validity is tracked by the FIFO count in the top.
module meas_result_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 66
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/meas_result_fifo.sv
// Captures done-strobed demodulator results into a first-word-fall-through FIFO with registered head outputs,
// plus sticky latest-result and drop accounting. Optional per-entry timestamp: MEAS_TIMESTAMP_EN.
module meas_result_fifo
    import meas_result_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ACCW  = ACCW_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       done,
    input  logic                       resultx,
    input  logic                       resulty,
    input  logic [ACCW-1:0]            xacc,
    input  logic [ACCW-1:0]            yacc,
    input  logic                       clear,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic                       rd_resultx,
    output logic                       rd_resulty,
    output logic [ACCW-1:0]            rd_xacc,
    output logic [ACCW-1:0]            rd_yacc,
    output logic [31:0]                rd_ts,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [15:0]                drop_count,
    output logic                       last_valid,
    output logic                       last_resultx,
    output logic                       last_resulty
);

    localparam int AW       = $clog2(DEPTH);
    localparam int EW       = entry_w(ACCW);
    localparam int OFF_YACC = off_yacc(ACCW);
    localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [AW:0]     count_r, count_nxt_s;
    logic            rd_valid_r, rd_resultx_r, rd_resulty_r;
    logic [ACCW-1:0] rd_xacc_r, rd_yacc_r;
    logic            overflow_r, last_valid_r, last_resultx_r, last_resulty_r;
    logic [15:0]     drop_count_r;
    logic            empty_s, full_s, pop_s, push_s, drop_s, bypass_s;
    logic [EW-1:0]   wr_data_s, mem_rdata_s, head_nxt_s;

`ifdef MEAS_TIMESTAMP_EN
    localparam int OFF_TS = off_ts(ACCW);
    logic [TS_W-1:0] ts_cnt_r, rd_ts_r;
`endif

    // handshake decode, entry packing and next-head selection
    always_comb begin
        empty_s  = (count_r == CNT_ZERO);
        full_s   = (count_r == CNT_FULL);
        pop_s    = !empty_s && rd_ready && !clear;
        push_s   = done && !clear && (!full_s || pop_s);
        drop_s   = done && !clear && full_s && !pop_s;
        wr_ptr_nxt_s = push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
        rd_ptr_nxt_s = pop_s  ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
        // the entry being written becomes the head when nothing older survives this cycle
        bypass_s = push_s && (empty_s || ((count_r == CNT_ONE) && pop_s));
        wr_data_s = {EW{1'b0}};
        wr_data_s[OFF_RX]             = resultx;
        wr_data_s[OFF_RY]             = resulty;
        wr_data_s[OFF_XACC +: ACCW]   = xacc;
        wr_data_s[OFF_YACC +: ACCW]   = yacc;
`ifdef MEAS_TIMESTAMP_EN
        wr_data_s[OFF_TS +: TS_W]     = ts_cnt_r;
`endif
        if (bypass_s) begin
            head_nxt_s = wr_data_s;
        end else begin
            head_nxt_s = mem_rdata_s;
        end
    end

    meas_result_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data_s),
        .raddr (rd_ptr_nxt_s),
        .rdata (mem_rdata_s)
    );

    // pointers, count, registered head and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r       <= {AW{1'b0}};
            rd_ptr_r       <= {AW{1'b0}};
            count_r        <= CNT_ZERO;
            rd_valid_r     <= 1'b0;
            rd_resultx_r   <= 1'b0;
            rd_resulty_r   <= 1'b0;
            rd_xacc_r      <= {ACCW{1'b0}};
            rd_yacc_r      <= {ACCW{1'b0}};
            overflow_r     <= 1'b0;
            drop_count_r   <= 16'h0000;
            last_valid_r   <= 1'b0;
            last_resultx_r <= 1'b0;
            last_resulty_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= CNT_ZERO;
            rd_valid_r   <= 1'b0;
            overflow_r   <= 1'b0;
            drop_count_r <= 16'h0000;
            last_valid_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            rd_valid_r <= (count_nxt_s != CNT_ZERO);
            if (count_nxt_s != CNT_ZERO) begin
                rd_resultx_r <= head_nxt_s[OFF_RX];
                rd_resulty_r <= head_nxt_s[OFF_RY];
                rd_xacc_r    <= head_nxt_s[OFF_XACC +: ACCW];
                rd_yacc_r    <= head_nxt_s[OFF_YACC +: ACCW];
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_count_r != DROP_SAT) begin
                    drop_count_r <= drop_count_r + 16'd1;
                end
            end
            if (done) begin
                last_valid_r   <= 1'b1;
                last_resultx_r <= resultx;
                last_resulty_r <= resulty;
            end
        end
    end

`ifdef MEAS_TIMESTAMP_EN
    // free-running stamp; only reset restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt_r <= {TS_W{1'b0}};
        end else begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
        end
    end

    // head timestamp follows the head entry like the other rd_* fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ts_r <= {TS_W{1'b0}};
        end else if (!clear && (count_nxt_s != CNT_ZERO)) begin
            rd_ts_r <= head_nxt_s[OFF_TS +: TS_W];
        end
    end

    assign rd_ts = rd_ts_r;
`else
    assign rd_ts = {TS_W{1'b0}};
`endif

    assign rd_valid     = rd_valid_r;
    assign rd_resultx   = rd_resultx_r;
    assign rd_resulty   = rd_resulty_r;
    assign rd_xacc      = rd_xacc_r;
    assign rd_yacc      = rd_yacc_r;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign drop_count   = drop_count_r;
    assign last_valid   = last_valid_r;
    assign last_resultx = last_resultx_r;
    assign last_resulty = last_resulty_r;

endmodule

// File: tb/tb_meas_result_fifo.sv
// Randomized and directed bench for meas_result_fifo against a queue-based reference model.
module tb_meas_result_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done = 1'b0, resultx = 1'b0, resulty = 1'b0;
    logic [31:0] xacc = 32'd0, yacc = 32'd0;
    logic        clear = 1'b0, rd_ready = 1'b0;
    logic        rd_valid, rd_resultx, rd_resulty;
    logic [31:0] rd_xacc, rd_yacc, rd_ts;
    logic [4:0]  count;
    logic        overflow, last_valid, last_resultx, last_resulty;
    logic [15:0] drop_count;

    typedef struct {
        logic        rx;
        logic        ry;
        logic [31:0] xa;
        logic [31:0] ya;
        logic [31:0] ts;
    } ent_t;

    ent_t        q[$];
    logic        m_ovf, m_lv, m_lrx, m_lry;
    logic [15:0] m_drop;
    logic [31:0] m_ts;
    int          checks = 0;
    int          errors = 0;

    meas_result_fifo dut (
        .clk(clk), .reset(reset), .done(done), .resultx(resultx), .resulty(resulty),
        .xacc(xacc), .yacc(yacc), .clear(clear), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_resultx(rd_resultx), .rd_resulty(rd_resulty),
        .rd_xacc(rd_xacc), .rd_yacc(rd_yacc), .rd_ts(rd_ts), .count(count),
        .overflow(overflow), .drop_count(drop_count), .last_valid(last_valid),
        .last_resultx(last_resultx), .last_resulty(last_resulty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_lv = 1'b0; m_lrx = 1'b0; m_lry = 1'b0;
        m_drop = 16'd0; m_ts = 32'd0;
    endtask

    // one clock edge of the reference behaviour, using the inputs held across that edge
    task automatic model_edge();
        ent_t e;
        bit   pop;
        if (clear) begin
            q.delete();
            m_ovf = 1'b0; m_drop = 16'd0; m_lv = 1'b0;
        end else begin
            pop = (q.size() > 0) && rd_ready;
            if (done) begin
                m_lv = 1'b1; m_lrx = resultx; m_lry = resulty;
            end
            if (done && q.size() == DEPTH && !pop) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            if (pop) void'(q.pop_front());
            if (done && q.size() < DEPTH) begin
                e.rx = resultx; e.ry = resulty; e.xa = xacc; e.ya = yacc; e.ts = m_ts;
                q.push_back(e);
            end
        end
        m_ts = m_ts + 32'd1;
    endtask

    task automatic check_all();
        check_eq("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
        check_eq("count", 64'(count), 64'(q.size()));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("drop_count", 64'(drop_count), 64'(m_drop));
        check_eq("last_valid", 64'(last_valid), 64'(m_lv));
        if (m_lv) begin
            check_eq("last_resultx", 64'(last_resultx), 64'(m_lrx));
            check_eq("last_resulty", 64'(last_resulty), 64'(m_lry));
        end
        if (q.size() != 0) begin
            check_eq("rd_resultx", 64'(rd_resultx), 64'(q[0].rx));
            check_eq("rd_resulty", 64'(rd_resulty), 64'(q[0].ry));
            check_eq("rd_xacc", 64'(rd_xacc), 64'(q[0].xa));
            check_eq("rd_yacc", 64'(rd_yacc), 64'(q[0].ya));
`ifdef MEAS_TIMESTAMP_EN
            check_eq("rd_ts", 64'(rd_ts), 64'(q[0].ts));
`else
            check_eq("rd_ts", 64'(rd_ts), 64'd0);
`endif
        end
    endtask

    task automatic check_zero_outputs();
        check_eq("rst_rd_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_rd_fields", 64'({rd_resultx, rd_resulty, rd_xacc}), 64'd0);
        check_eq("rst_rd_yacc", 64'(rd_yacc), 64'd0);
        check_eq("rst_rd_ts", 64'(rd_ts), 64'd0);
        check_eq("rst_count", 64'(count), 64'd0);
        check_eq("rst_status", 64'({overflow, drop_count, last_valid, last_resultx, last_resulty}), 64'd0);
    endtask

    task automatic step_data(input logic d, input logic clr, input logic rdy,
                             input logic rx, input logic ry, input logic [31:0] xa, input logic [31:0] ya);
        done = d; clear = clr; rd_ready = rdy;
        resultx = rx; resulty = ry; xacc = xa; yacc = ya;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic step(input logic d, input logic clr, input logic rdy);
        step_data(d, clr, rdy, 1'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs();
        #2 reset = 1'b0;

        // single result with fixed fields
        step_data(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFB);
        check_eq("t1_count", 64'(count), 64'd1);
        check_eq("t1_xacc", 64'(rd_xacc), 64'h0000_1234);
        check_eq("t1_yacc", 64'(rd_yacc), 64'hFFFF_FFFB);
        step(1'b0, 1'b0, 1'b1);

        // fill to full, then one dropped result
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("t2_full", 64'(count), 64'd16);
        step(1'b1, 1'b0, 1'b0);
        check_eq("t2_drop", 64'(drop_count), 64'd1);

        // full with simultaneous pop and write
        step(1'b1, 1'b0, 1'b1);
        check_eq("t3_count", 64'(count), 64'd16);

        // drain, then wrap with toggling ready
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'(i % 2));
        for (int i = 0; i < 44; i++) step(1'b0, 1'b0, 1'(i % 2));
        check_eq("t4_empty", 64'(count), 64'd0);

        // clear with coincident done at count 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_eq("t5_count", 64'(count), 64'd0);
        check_eq("t5_last_valid", 64'(last_valid), 64'd0);

        // async reset mid-stream
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_zero_outputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // two results seven cycles apart
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 45));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
